// File: rtl/pipeline_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipeline_stage_elastic
//
// A chain of DEPTH pipeline registers. Each register is WIDTH bits wide and has
// its own valid bit. A ready/valid handshake sits on both ends, and every stage
// can stall on its own. Bubbles are compacted: a stalled valid stage lets the
// upstream stages advance into an empty slot behind it. A synchronous flush
// kills every in-flight entry. An empty stage holds the BUBBLE word, for
// example the RV32I NOP.
//
// Parameters:
//   WIDTH   data bits per stage
//   DEPTH   number of register stages, 1..8
//   BUBBLE  word held by an empty stage, truncated or zero-extended to WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   in_valid   upstream presents in_data
//   in_ready   block accepts in_data this cycle (combinational)
//   in_data    upstream payload
//   out_valid  last stage holds valid data
//   out_ready  downstream consumes out_data this cycle
//   out_data   last-stage data register, BUBBLE when that stage is empty
//   flush      kill all in-flight entries at the next clk edge
//   occupancy  number of valid stages, 0..DEPTH
// -----------------------------------------------------------------------------
module pipeline_stage_elastic #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter     BUBBLE = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [3:0]       occupancy
);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("pipeline_stage_elastic: DEPTH must be in 1..8");
        end
    endgenerate

    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             in_take;

    // A stage may advance when it or any stage downstream of it has room,
    // or when the consumer drains the last stage. Compute this as a running
    // OR from the output side. This avoids a chain that reads back its own
    // vector.
    always_comb begin
        logic room;
        // NOTE: assign every always_comb output before any branch or loop,
        // so that no path leaves it unassigned and no latch is inferred.
        adv  = '0;
        room = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room   = room | ~valid_q[i];
            adv[i] = room;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign in_take   = in_valid & in_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + 4'(valid_q[i]);
        end
    end

    // A stage takes its upstream neighbour's contents when it advances.
    // When the incoming entry is empty, the stage loads BUBBLE, so that an
    // empty stage always presents a known word.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset along with the valid bits,
        // because an empty stage must present BUBBLE right after reset.
        if (!rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignments only,
                // so every stage reads its neighbour's pre-edge value.
                valid_q[i] <= 1'b0;
                data_q[i]  <= BUBBLE_W;
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_take;
                data_q[0]  <= in_take ? in_data : BUBBLE_W;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= valid_q[i-1] ? data_q[i-1] : BUBBLE_W;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// -----------------------------------------------------------------------------
// Directed testbench for pipeline_stage_elastic with WIDTH=32, DEPTH=3 and
// BUBBLE=32'h00000013. All expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_elastic;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 3;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [3:0]       occupancy;

    int pass_cnt  = 0;
    int check_cnt = 0;

    pipeline_stage_elastic #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .BUBBLE(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance past one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // ---------------- reset then idle ----------------
        tick();
        tick();
        rst = 1'b1;
        settle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       NOP);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // ---------------- streaming A1..A5 ----------------
        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            in_valid = (k <= 5);
            in_data  = 32'hA000_0000 + 32'(k);
            settle();
            check($sformatf("stream_in_ready_%0d", k), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("stream_out_valid_%0d", k), 32'(out_valid),
                  (k >= 3) ? 32'd1 : 32'd0);
            check($sformatf("stream_out_data_%0d", k), out_data,
                  (k >= 3) ? 32'hA000_0000 + 32'(k - 2) : NOP);
            check($sformatf("stream_occ_%0d", k), 32'(occupancy),
                  (k <= 3) ? 32'(k) : (k <= 5) ? 32'd3 : 32'(8 - k));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 32'(out_valid), 32'd0);
        check("stream_drain_data",  out_data,       NOP);
        check("stream_drain_occ",   32'(occupancy), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'hB000_0001; tick();
        in_data = 32'hB000_0002; tick();
        in_data = 32'hB000_0003; tick();
        in_data = 32'hB000_0004;
        settle();
        check("bp_full_occ",      32'(occupancy), 32'd3);
        check("bp_full_in_ready", 32'(in_ready),  32'd0);
        check("bp_full_data",     out_data,       32'hB000_0001);
        check("bp_full_valid",    32'(out_valid), 32'd1);
        tick();
        check("bp_hold_data", out_data,       32'hB000_0001);
        check("bp_hold_occ",  32'(occupancy), 32'd3);
        out_ready = 1'b1;
        settle();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_swap_data", out_data,       32'hB000_0002);
        check("bp_swap_occ",  32'(occupancy), 32'd3);
        in_valid = 1'b0;
        tick();
        check("bp_drain_b3", out_data, 32'hB000_0003);
        tick();
        check("bp_drain_b4", out_data, 32'hB000_0004);
        tick();
        check("bp_drain_occ", 32'(occupancy), 32'd0);

        // ---------------- bubble compaction ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 32'hC000_0002;
        tick();
        check("bc_occ_gap", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        settle();
        check("bc_in_ready_stalled", 32'(in_ready), 32'd1);
        tick();
        check("bc_occ_packed", 32'(occupancy), 32'd2);
        check("bc_out_c1",     out_data,       32'hC000_0001);
        out_ready = 1'b1;
        tick();
        check("bc_out_c2",     out_data,       32'hC000_0002);
        check("bc_occ_after1", 32'(occupancy), 32'd1);
        tick();
        check("bc_empty_data", out_data,       NOP);
        check("bc_empty_occ",  32'(occupancy), 32'd0);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'hD000_0001; tick();
        in_data = 32'hD000_0002; tick();
        in_data = 32'hD000_0003; tick();
        check("fl_pre_occ", 32'(occupancy), 32'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hD000_0004;
        settle();
        check("fl_in_ready",  32'(in_ready),  32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("fl_post_occ",   32'(occupancy), 32'd0);
        check("fl_post_valid", 32'(out_valid), 32'd0);
        check("fl_post_data",  out_data,       NOP);
        tick();
        tick();
        tick();
        check("fl_no_capture_occ",  32'(occupancy), 32'd0);
        check("fl_no_capture_data", out_data,       NOP);

        // ---------------- reset vs flush ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 32'hE000_0001; tick();
        in_data = 32'hE000_0002; tick();
        in_data = 32'hE000_0003; tick();
        check("rf_pre_occ", 32'(occupancy), 32'd3);
        rst       = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'hE000_0004;
        tick();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'hE000_0005;
        settle();
        check("rf_occ",      32'(occupancy), 32'd0);
        check("rf_valid",    32'(out_valid), 32'd0);
        check("rf_data",     out_data,       NOP);
        check("rf_in_ready", 32'(in_ready),  32'd1);
        tick();
        check("rf_accept_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        tick();
        check("rf_mid_valid", 32'(out_valid), 32'd0);
        tick();
        check("rf_out_valid", 32'(out_valid), 32'd1);
        check("rf_out_data",  out_data,       32'hE000_0005);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
